// File: rtl/avalon_pio_gpio_if.sv
// avalon_pio_gpio_if: Avalon-MM slave bus bundle for the GPIO register port
interface avalon_pio_gpio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pio_gpio.sv
// avalon_pio_gpio: Avalon-MM GPIO with direction, set/clear, synced inputs, edge capture and masked irq
module avalon_pio_gpio #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_OUT  = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_DIR  = '0,
    parameter int                    EDGE_TYPE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_pio_gpio_if.slave      bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);
    logic [DATA_WIDTH-1:0] data_out, dir, irqmask, edgecap;
    logic [DATA_WIDTH-1:0] s1, s2, s3, edge_raw, evt, wd;
    logic [1:0]            prime;
    logic                  wr;
    logic [31:0]           rd;

    assign wr = bus.chipselect & ~bus.write_n;
    assign wd = bus.writedata[DATA_WIDTH-1:0];
    assign edge_raw = EDGE_TYPE == 1 ? ~s2 & s3 : EDGE_TYPE == 2 ? s2 ^ s3 : s2 & ~s3;
    // events only count on input bits once the synchroniser has filled with real pin values
    assign evt = prime == 2'd3 ? edge_raw & ~dir : '0;

    // synchroniser, edge history and priming counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            prime <= '0;
        end else begin
            s1    <= in_port;
            s2    <= s1;
            s3    <= s2;
            prime <= prime == 2'd3 ? prime : prime + 2'd1;
        end
    end

    // register writes; a capture on the same bit beats a write-1-to-clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_OUT;
            dir      <= RESET_DIR;
            irqmask  <= '0;
            edgecap  <= '0;
        end else begin
            if (wr && bus.address == 3'd0) data_out <= wd;
            if (wr && bus.address == 3'd4) data_out <= data_out | wd;
            if (wr && bus.address == 3'd5) data_out <= data_out & ~wd;
            if (wr && bus.address == 3'd1) dir <= wd;
            if (wr && bus.address == 3'd2) irqmask <= wd;
            edgecap <= (edgecap & ~(wr && bus.address == 3'd3 ? wd : '0)) | evt;
        end
    end

    // zero-wait-state read mux, upper bits zero-extended
    always_comb begin
        rd = '0;
        case (bus.address)
            3'd0:    rd[DATA_WIDTH-1:0] = (dir & data_out) | (~dir & s2);
            3'd1:    rd[DATA_WIDTH-1:0] = dir;
            3'd2:    rd[DATA_WIDTH-1:0] = irqmask;
            3'd3:    rd[DATA_WIDTH-1:0] = edgecap;
            default: rd = '0;
        endcase
    end

    assign bus.readdata = rd;
    assign out_port     = data_out;
    assign oe           = dir;
    assign irq          = |(edgecap & irqmask);
endmodule

// File: tb/tb_avalon_pio_gpio.sv
// tb_avalon_pio_gpio: directed self-checking bench for avalon_pio_gpio at widths 8, 32 and 1
module tb_avalon_pio_gpio;
    logic        clk = 0;
    logic        reset = 1;
    logic [2:0]  address = 0;
    logic        write_n = 1;
    logic [31:0] wdata = 0;
    logic        cs8 = 0, cs32 = 0, cs1 = 0;
    logic [7:0]  in8 = 8'h3C, out8, oe8;
    logic [31:0] in32 = 0, out32, oe32;
    logic        in1 = 0, out1, oe1;
    logic        irq8, irq32, irq1;
    logic [31:0] rd;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    avalon_pio_gpio_if bus8 ();
    avalon_pio_gpio_if bus32 ();
    avalon_pio_gpio_if bus1 ();

    assign bus8.address  = address;
    assign bus32.address = address;
    assign bus1.address  = address;
    assign bus8.write_n  = write_n;
    assign bus32.write_n = write_n;
    assign bus1.write_n  = write_n;
    assign bus8.writedata  = wdata;
    assign bus32.writedata = wdata;
    assign bus1.writedata  = wdata;
    assign bus8.chipselect  = cs8;
    assign bus32.chipselect = cs32;
    assign bus1.chipselect  = cs1;

    avalon_pio_gpio #(.DATA_WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h00), .EDGE_TYPE(0)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8), .in_port(in8), .out_port(out8), .oe(oe8), .irq(irq8));
    avalon_pio_gpio #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .bus(bus32), .in_port(in32), .out_port(out32), .oe(oe32), .irq(irq32));
    avalon_pio_gpio #(.DATA_WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .in_port(in1), .out_port(out1), .oe(oe1), .irq(irq1));

    task automatic wr(input int which, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        wdata   = d;
        write_n = 0;
        cs8  = which == 0;
        cs32 = which == 1;
        cs1  = which == 2;
        @(posedge clk);
        #1;
        write_n = 1;
        cs8 = 0;
        cs32 = 0;
        cs1 = 0;
    endtask

    task automatic rdreg(input int which, input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = which == 0 ? bus8.readdata : which == 1 ? bus32.readdata : bus1.readdata;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        tests++; if (out8 !== 8'hA5) begin fails++; $display("FAIL reset_out got %h want a5", out8); end
        tests++; if (oe8 !== 8'h00) begin fails++; $display("FAIL reset_oe got %h want 00", oe8); end
        tests++; if (irq8 !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", irq8); end
        @(negedge clk);
        reset = 0;
        cycles(4);
        rdreg(0, 3'd0, rd);
        tests++; if (rd !== 32'h3C) begin fails++; $display("FAIL reset_read_in got %h want 0000003c", rd); end
        wr(0, 3'd0, 32'h55);
        tests++; if (out8 !== 8'h55) begin fails++; $display("FAIL data_write got %h want 55", out8); end
        @(negedge clk);
        #2;
        reset = 1;
        #1;
        tests++; if (out8 !== 8'hA5) begin fails++; $display("FAIL async_reset got %h want a5", out8); end
        @(negedge clk);
        reset = 0;
        cycles(4);
    endtask

    task automatic test_data_ops;
        wr(0, 3'd1, 32'hF0);
        wr(0, 3'd0, 32'h12);
        tests++; if (out8 !== 8'h12) begin fails++; $display("FAIL data_load got %h want 12", out8); end
        wr(0, 3'd4, 32'h0C);
        tests++; if (out8 !== 8'h1E) begin fails++; $display("FAIL outset got %h want 1e", out8); end
        wr(0, 3'd5, 32'h02);
        tests++; if (out8 !== 8'h1C) begin fails++; $display("FAIL outclr got %h want 1c", out8); end
        in8 = 8'h0F;
        cycles(4);
        rdreg(0, 3'd0, rd);
        tests++; if (rd !== 32'h1F) begin fails++; $display("FAIL data_mixed got %h want 0000001f", rd); end
        rdreg(0, 3'd1, rd);
        tests++; if (rd !== 32'hF0) begin fails++; $display("FAIL dir_read got %h want 000000f0", rd); end
        tests++; if (oe8 !== 8'hF0) begin fails++; $display("FAIL oe got %h want f0", oe8); end
        rdreg(0, 3'd4, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL outset_read got %h want 0", rd); end
        rdreg(0, 3'd3, rd);
        tests++; if (rd !== 32'h03) begin fails++; $display("FAIL edgecap_rise got %h want 00000003", rd); end
        wr(0, 3'd6, 32'hFF);
        tests++; if (out8 !== 8'h1C || oe8 !== 8'hF0) begin fails++; $display("FAIL addr6_write got %h/%h want 1c/f0", out8, oe8); end
        rdreg(0, 3'd6, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL addr6_read got %h want 0", rd); end
        wr(0, 3'd3, 32'hFF);
        rdreg(0, 3'd3, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL edgecap_w1c got %h want 0", rd); end
    endtask

    task automatic test_edge_irq;
        wr(0, 3'd2, 32'h01);
        rdreg(0, 3'd2, rd);
        tests++; if (rd !== 32'h01) begin fails++; $display("FAIL irqmask_read got %h want 01", rd); end
        in8 = 8'h0E;
        cycles(5);
        rdreg(0, 3'd3, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL falling_ignored got %h want 0", rd); end
        @(negedge clk);
        in8 = 8'h0F;
        @(posedge clk);
        cycles(1);
        tests++; if (irq8 !== 1'b0) begin fails++; $display("FAIL irq_early got %b want 0", irq8); end
        cycles(1);
        tests++; if (irq8 !== 1'b1) begin fails++; $display("FAIL irq_k2 got %b want 1", irq8); end
        rdreg(0, 3'd3, rd);
        tests++; if (rd !== 32'h01) begin fails++; $display("FAIL edgecap_bit0 got %h want 01", rd); end
        wr(0, 3'd3, 32'h01);
        tests++; if (irq8 !== 1'b0) begin fails++; $display("FAIL irq_clear got %b want 0", irq8); end
        in8 = 8'h0D;
        cycles(4);
        in8 = 8'h0F;
        cycles(4);
        rdreg(0, 3'd3, rd);
        tests++; if (rd !== 32'h02 || irq8 !== 1'b0) begin fails++; $display("FAIL masked_bit1 got %h/%b want 02/0", rd, irq8); end
        wr(0, 3'd3, 32'h02);
        in8 = 8'h1F;
        cycles(4);
        wr(0, 3'd1, 32'hE0);
        cycles(4);
        rdreg(0, 3'd3, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL output_bit_no_capture got %h want 0", rd); end
    endtask

    task automatic test_priming;
        in8 = 8'hFF;
        @(negedge clk);
        reset = 1;
        cycles(2);
        @(negedge clk);
        reset = 0;
        cycles(6);
        rdreg(0, 3'd3, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL priming got %h want 0", rd); end
        in8 = 8'hF7;
        cycles(3);
        in8 = 8'hFF;
        cycles(4);
        rdreg(0, 3'd3, rd);
        tests++; if (rd !== 32'h08) begin fails++; $display("FAIL pulse_bit3 got %h want 08", rd); end
    endtask

    task automatic test_simultaneous;
        in8 = 8'hFB;
        cycles(4);
        @(negedge clk);
        in8 = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        wr(0, 3'd3, 32'h0C);
        rdreg(0, 3'd3, rd);
        tests++; if (rd !== 32'h04) begin fails++; $display("FAIL capture_beats_clear got %h want 04", rd); end
    endtask

    task automatic test_widths;
        rdreg(1, 3'd6, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL w32_addr6 got %h want 0", rd); end
        wr(1, 3'd1, 32'hFFFFFFFF);
        wr(1, 3'd0, 32'hDEADBEEF);
        rdreg(1, 3'd0, rd);
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL w32_data got %h want deadbeef", rd); end
        rdreg(2, 3'd6, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL w1_addr6 got %h want 0", rd); end
        wr(2, 3'd1, 32'hFFFFFFFF);
        wr(2, 3'd0, 32'hFFFFFFFF);
        rdreg(2, 3'd0, rd);
        tests++; if (rd !== 32'h1) begin fails++; $display("FAIL w1_data got %h want 00000001", rd); end
        tests++; if (oe1 !== 1'b1 || out1 !== 1'b1) begin fails++; $display("FAIL w1_pins got %b/%b want 1/1", oe1, out1); end
        wr(2, 3'd1, 32'hFFFFFFFE);
        rdreg(2, 3'd0, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL w1_input got %h want 0", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_data_ops;
        test_edge_irq;
        test_priming;
        test_simultaneous;
        test_widths;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
